// File: rtl/snn_frame_loader.sv
// snn_frame_loader: unpacks UART bytes LSB-first into the 1-bit input RAM,
// pulses start once a full image is stored, then holds off until the SNN
// core reports done. An inter-byte timeout discards partial frames.
//
// Handshake: rx_rdy is a one-cycle strobe qualifying rx_data. There is no
// backpressure; a strobe arriving in WRITE or BUSY drops the byte and is
// flagged on overrun one cycle later. core_done is a strobe honoured only
// in BUSY.
module snn_frame_loader #(
    parameter int NUM_BITS    = 784,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              core_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    output logic              ram_we,
    output logic              start,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]     T_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W:0]   BITS_END = (ADDR_W + 1)'(NUM_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_BUSY  = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [7:0]        shreg, shreg_n;
    logic [ADDR_W-1:0] baddr, baddr_n;
    logic [2:0]        bcnt, bcnt_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic              start_q, err_q, ovr_q;
    logic              start_n, err_n, ovr_n;
    logic              last_bit;

    // True when the bit being written is the final bit of the image.
    assign last_bit = (({1'b0, baddr} + (ADDR_W + 1)'(1)) == BITS_END);

    // State and datapath registers; pulse outputs are registered here too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            baddr   <= '0;
            bcnt    <= '0;
            tcnt    <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            baddr   <= baddr_n;
            bcnt    <= bcnt_n;
            tcnt    <= tcnt_n;
            start_q <= start_n;
            err_q   <= err_n;
            ovr_q   <= ovr_n;
        end
    end

    // Next-state, datapath updates and write enable.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        baddr_n = baddr;
        bcnt_n  = bcnt;
        tcnt_n  = tcnt;
        err_n   = 1'b0;
        ovr_n   = 1'b0;
        ram_we  = 1'b0;
        case (state)
            S_IDLE: begin
                baddr_n = '0;
                if (rx_rdy) begin
                    shreg_n = rx_data;
                    bcnt_n  = '0;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                ram_we  = 1'b1;
                ovr_n   = rx_rdy;
                shreg_n = shreg >> 1;
                baddr_n = baddr + ADDR_W'(1);
                bcnt_n  = bcnt + 3'd1;
                if (bcnt == 3'd7) begin
                    if (last_bit) begin
                        // Never let baddr step past the last image bit.
                        baddr_n = '0;
                        state_n = S_START;
                    end else begin
                        tcnt_n  = '0;
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                tcnt_n = tcnt + TW'(1);
                // A byte on the terminal cycle still wins over the timeout.
                if (rx_rdy) begin
                    shreg_n = rx_data;
                    bcnt_n  = '0;
                    state_n = S_WRITE;
                end else if (tcnt == T_LAST) begin
                    err_n   = 1'b1;
                    baddr_n = '0;
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                baddr_n = '0;
                state_n = S_BUSY;
            end
            S_BUSY: begin
                ovr_n = rx_rdy;
                if (core_done) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                baddr_n = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // start is raised for the single cycle spent in START.
    always_comb begin
        start_n = (state_n == S_START);
    end

    assign ram_addr  = baddr;
    assign ram_wdata = shreg[0];
    assign start     = start_q;
    assign busy      = (state == S_START) || (state == S_BUSY);
    assign frame_err = err_q;
    assign overrun   = ovr_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_snn_frame_loader.sv
// Directed bench for snn_frame_loader with a short timeout (100 cycles).
module tb_snn_frame_loader;

    localparam int NB = 784;
    localparam int AW = 10;
    localparam int TO = 100;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          core_done = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_wdata, ram_we, start, busy, frame_err, overrun;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    // RAM model: value plus the tag of the frame that wrote it.
    logic mem_val [0:(1<<AW)-1];
    int   mem_tag [0:(1<<AW)-1];
    int   cur_tag = 0;
    int   wr_cnt = 0, start_cnt = 0, err_cnt = 0, ovr_cnt = 0;

    snn_frame_loader #(.NUM_BITS(NB), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .core_done(core_done), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .start(start), .busy(busy), .frame_err(frame_err),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // RAM model and pulse counters
    always @(posedge clk) begin
        if (ram_we) begin
            mem_val[ram_addr] <= ram_wdata;
            mem_tag[ram_addr] <= cur_tag;
            wr_cnt <= wr_cnt + 1;
        end
        if (start)     start_cnt <= start_cnt + 1;
        if (frame_err) err_cnt   <= err_cnt + 1;
        if (overrun)   ovr_cnt   <= ovr_cnt + 1;
    end

    // Watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy  = 1'b0;
    endtask

    // Sends bytes k ^ seed for k = 0..97 and checks start timing and RAM contents.
    task automatic send_frame(input logic [7:0] seed);
        int w0, s0, e0, errs;
        logic [7:0] bv;
        cur_tag = cur_tag + 1;
        w0 = wr_cnt; s0 = start_cnt; e0 = err_cnt;
        for (int k = 0; k < NB/8 - 1; k++) begin
            send_byte(8'(k) ^ seed);
            repeat (27) tick();
        end
        send_byte(8'(NB/8 - 1) ^ seed);
        repeat (7) tick();
        chk("start_before_n9", start, 1'b0);
        tick();
        chk("start_at_n9", start, 1'b1);
        chk("busy_at_n9", busy, 1'b1);
        tick();
        chk("start_one_cycle", start, 1'b0);
        chk("busy_after_start", busy, 1'b1);
        chk("state_busy", dbg_state, ST_BUSY);
        chk("frame_writes", wr_cnt - w0, NB);
        chk("frame_starts", start_cnt - s0, 1);
        chk("frame_no_err", err_cnt - e0, 0);
        errs = 0;
        for (int a = 0; a < NB; a++) begin
            bv = 8'(a / 8) ^ seed;
            if (mem_tag[a] !== cur_tag || mem_val[a] !== bv[a % 8]) errs++;
        end
        chk("frame_data", errs, 0);
    endtask

    task automatic finish_core();
        repeat (3) tick();
        chk("busy_hold", busy, 1'b1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("busy_cleared", busy, 1'b0);
        chk("idle_after_done", dbg_state, ST_IDLE);
    endtask

    initial begin
        logic [7:0] bv;
        int o0, e0;

        // Reset state
        #2;
        chk("rst_we", ram_we, 1'b0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        tick();
        rst_n = 1'b1;
        tick();

        // Full frame, byte k = k
        send_frame(8'h00);

        // Overrun during BUSY
        rx_data = 8'hEE;
        rx_rdy  = 1'b1;
        chk("busy_ovr_no_we", ram_we, 1'b0);
        tick();
        rx_rdy = 1'b0;
        chk("busy_ovr_pulse", overrun, 1'b1);
        chk("busy_ovr_busy", busy, 1'b1);
        chk("busy_ovr_state", dbg_state, ST_BUSY);
        chk("busy_ovr_we", ram_we, 1'b0);
        tick();
        chk("busy_ovr_end", overrun, 1'b0);
        finish_core();

        // core_done outside BUSY is ignored
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("stray_done_idle", dbg_state, ST_IDLE);
        chk("stray_done_busy", busy, 1'b0);

        // Bit order: 0xA5 as byte 0
        cur_tag = cur_tag + 1;
        bv = 8'hA5;
        send_byte(bv);
        for (int i = 0; i < 8; i++) begin
            chk("bo_we", ram_we, 1'b1);
            chk("bo_addr", ram_addr, i);
            chk("bo_data", ram_wdata, bv[i]);
            tick();
        end
        chk("bo_wait", dbg_state, ST_WAIT);
        chk("bo_we_off", ram_we, 1'b0);

        // Timeout after 5 bytes
        for (int k = 1; k < 5; k++) begin
            repeat (10) tick();
            send_byte(8'(k));
            repeat (8) tick();
        end
        chk("to_in_wait", dbg_state, ST_WAIT);
        e0 = err_cnt;
        repeat (99) tick();
        chk("to_not_yet", frame_err, 1'b0);
        chk("to_still_wait", dbg_state, ST_WAIT);
        tick();
        chk("to_err_pulse", frame_err, 1'b1);
        chk("to_idle", dbg_state, ST_IDLE);
        chk("to_addr_zero", ram_addr, 0);
        tick();
        chk("to_err_end", frame_err, 1'b0);
        chk("to_err_count", err_cnt - e0, 1);

        // Fresh frame after timeout starts at address 0
        send_frame(8'h5A);
        finish_core();

        // Timeout race: byte on the terminal WAIT cycle
        send_byte(8'h11);
        repeat (8) tick();
        repeat (99) tick();
        bv = 8'h3C;
        rx_data = bv;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy = 1'b0;
        chk("race_no_err", frame_err, 1'b0);
        chk("race_write", dbg_state, ST_WRITE);
        for (int i = 0; i < 8; i++) begin
            chk("race_addr", ram_addr, 8 + i);
            chk("race_data", ram_wdata, bv[i]);
            tick();
        end
        chk("race_wait", dbg_state, ST_WAIT);
        repeat (100) tick();
        chk("race_to_err", frame_err, 1'b1);
        chk("race_to_idle", dbg_state, ST_IDLE);

        // Overrun on the 4th WRITE cycle
        o0 = ovr_cnt;
        bv = 8'hC3;
        send_byte(bv);
        repeat (3) tick();
        rx_data = 8'hFF;
        rx_rdy  = 1'b1;
        chk("wovr_addr3", ram_addr, 3);
        chk("wovr_data3", ram_wdata, bv[3]);
        tick();
        rx_rdy = 1'b0;
        chk("wovr_pulse", overrun, 1'b1);
        chk("wovr_addr4", ram_addr, 4);
        chk("wovr_data4", ram_wdata, bv[4]);
        chk("wovr_state", dbg_state, ST_WRITE);
        repeat (3) tick();
        chk("wovr_end", overrun, 1'b0);
        chk("wovr_addr7", ram_addr, 7);
        chk("wovr_data7", ram_wdata, bv[7]);
        tick();
        chk("wovr_wait", dbg_state, ST_WAIT);
        chk("wovr_next_addr", ram_addr, 8);
        chk("wovr_count", ovr_cnt - o0, 1);
        repeat (100) tick();
        chk("wovr_to_idle", dbg_state, ST_IDLE);

        // Reset on the 3rd write cycle of byte 10
        for (int k = 0; k < 10; k++) begin
            send_byte(8'(k));
            repeat (27) tick();
        end
        send_byte(8'd10);
        repeat (2) tick();
        chk("mid_addr", ram_addr, 82);
        chk("mid_we", ram_we, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_we", ram_we, 1'b0);
        chk("mrst_addr", ram_addr, 0);
        chk("mrst_wdata", ram_wdata, 1'b0);
        chk("mrst_start", start, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_err", frame_err, 1'b0);
        chk("mrst_ovr", overrun, 1'b0);
        chk("mrst_state", dbg_state, ST_IDLE);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'hC7);
        finish_core();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
